// File: rtl/vga_fb_scaler.sv
// vga_fb_scaler: VGA timing generator with a pixel-replicating framebuffer
// reader and frame-latched test patterns. All state advances on pix_ce.
module vga_fb_scaler #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SCALE    = 4,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic [1:0]        pattern_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [11:0]       mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              frame_start
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOT);
  localparam int unsigned VW       = $clog2(V_TOT);
  localparam int unsigned FB_W     = H_ACTIVE / SCALE;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam int unsigned H_SYNC_S = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_L = H_SYNC_S + H_SYNC - 1;
  localparam int unsigned V_SYNC_S = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_L = V_SYNC_S + V_SYNC - 1;
  localparam int unsigned PW       = HW + VW + 4;
  localparam logic        SYNC_ACT = 1'(SYNC_POL);

  logic [HW-1:0]     r_h_cnt;
  logic [VW-1:0]     r_v_cnt;
  logic [ADDR_W-1:0] r_fb_x;
  logic [ADDR_W-1:0] r_line_base;
  logic [1:0]        r_pat;
  logic [PW-1:0]     r_pipe [0:MEM_LAT];

  logic w_h_last, w_v_last, w_h_vis, w_v_vis, w_vis, w_hs, w_vs;
  logic w_h_end, w_sub_end, w_rep_end, w_origin;
  logic w_o_val, w_o_vis, w_o_hs, w_o_vs;
  logic [HW-1:0] w_o_h;
  logic [VW-1:0] w_o_v;
  logic [2:0]    w_bar;
  logic          w_grid;
  logic [11:0]   w_rgb;

  assign w_h_last  = (r_h_cnt == HW'(H_TOT - 1));
  assign w_v_last  = (r_v_cnt == VW'(V_TOT - 1));
  assign w_h_vis   = (r_h_cnt < HW'(H_ACTIVE));
  assign w_v_vis   = (r_v_cnt < VW'(V_ACTIVE));
  assign w_vis     = w_h_vis && w_v_vis;
  assign w_hs      = (r_h_cnt >= HW'(H_SYNC_S)) && (r_h_cnt <= HW'(H_SYNC_L));
  assign w_vs      = (r_v_cnt >= VW'(V_SYNC_S)) && (r_v_cnt <= VW'(V_SYNC_L));
  assign w_h_end   = (r_h_cnt == HW'(H_ACTIVE - 1));
  assign w_sub_end = ((r_h_cnt & HW'(SCALE - 1)) == HW'(SCALE - 1));
  assign w_rep_end = ((r_v_cnt & VW'(SCALE - 1)) == VW'(SCALE - 1));
  assign w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Raster counters, multiplier-free address generation and pattern latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_fb_x      <= '0;
      r_line_base <= '0;
      r_pat       <= 2'd0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
    end else if (pix_ce) begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
      if (w_h_last) begin
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end
      if (w_h_end) begin
        r_fb_x <= '0;
      end else if (w_h_vis && w_sub_end) begin
        r_fb_x <= r_fb_x + 1'b1;
      end
      if (w_h_last && w_v_last) begin
        r_line_base <= '0;
      end else if (w_h_end && w_v_vis && w_rep_end) begin
        r_line_base <= r_line_base + ADDR_W'(FB_W);
      end
      mem_addr <= w_vis ? (r_line_base + r_fb_x) : '0;
      mem_rd   <= w_vis;
      if (w_origin) begin
        r_pat <= pattern_sel;
      end
    end
  end

  // Delay line carrying timing flags and coordinates alongside the RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= int'(MEM_LAT); i++) begin
        r_pipe[i] <= '0;
      end
    end else if (pix_ce) begin
      r_pipe[0] <= {1'b1, w_vis, w_hs, w_vs, r_h_cnt, r_v_cnt};
      for (int i = 1; i <= int'(MEM_LAT); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign {w_o_val, w_o_vis, w_o_hs, w_o_vs, w_o_h, w_o_v} = r_pipe[MEM_LAT];

  // Colour source for the pixel leaving the delay line
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_o_h >= HW'(i * BAR_W)) w_bar = 3'(i);
    end
    w_grid = ((w_o_h & HW'(31)) == '0) || ((w_o_v & VW'(31)) == '0);
    case (r_pat)
      2'd1:    w_rgb = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
      2'd2:    w_rgb = w_grid ? 12'hFFF : 12'h000;
      2'd3:    w_rgb = 12'hFFF;
      default: w_rgb = mem_data;
    endcase
  end

  // Output registers: syncs, display enable, RGB and frame marker
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      red         <= 4'h0;
      green       <= 4'h0;
      blue        <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        hsync              <= w_o_hs ? SYNC_ACT : ~SYNC_ACT;
        vsync              <= w_o_vs ? SYNC_ACT : ~SYNC_ACT;
        de                 <= w_o_val && w_o_vis;
        {red, green, blue} <= (w_o_val && w_o_vis) ? w_rgb : 12'h000;
        frame_start        <= w_o_val && (w_o_h == '0) && (w_o_v == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scaler.sv
// tb_vga_fb_scaler: two shrunken raster configurations compared every clk
// against a position-based reference model fed by a latency-modelled RAM.
module tb_vga_fb_scaler;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [1:0] pattern_sel;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input int g, input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h at %0t", g, name, act, exp, $time);
    end
  endtask

  // Framebuffer word shown at output position (h,v)
  function automatic int unsigned fb_addr(int unsigned h, int unsigned v, int unsigned scale, int unsigned fbw);
    return (v / scale) * fbw + h / scale;
  endfunction

  // Test-pattern colour at output position (h,v)
  function automatic logic [11:0] pat_rgb(logic [1:0] p, int unsigned h, int unsigned v, int unsigned ha);
    logic [2:0] bar;
    bar = 3'(h / (ha / 8));
    case (p)
      2'd1:    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      2'd2:    return ((h % 32 == 0) || (v % 32 == 0)) ? 12'hFFF : 12'h000;
      2'd3:    return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned HA  = (g == 0) ? 32 : 16;
    localparam int unsigned HFP = (g == 0) ? 4 : 2;
    localparam int unsigned HS  = (g == 0) ? 6 : 3;
    localparam int unsigned HBP = (g == 0) ? 6 : 3;
    localparam int unsigned VA  = (g == 0) ? 16 : 8;
    localparam int unsigned VFP = (g == 0) ? 2 : 1;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = (g == 0) ? 3 : 2;
    localparam int unsigned S   = (g == 0) ? 4 : 2;
    localparam int unsigned SP  = (g == 0) ? 0 : 1;
    localparam int unsigned L   = (g == 0) ? 1 : 3;
    localparam int unsigned AW  = 5;
    localparam int unsigned HT  = HA + HFP + HS + HBP;
    localparam int unsigned VT  = VA + VFP + VS + VBP;
    localparam int unsigned FT  = HT * VT;
    localparam int unsigned FBW = HA / S;
    localparam int unsigned FBN = FBW * (VA / S);
    localparam logic        SA  = 1'(SP);

    logic [AW-1:0] mem_addr;
    logic          mem_rd, hsync, vsync, de, frame_start;
    logic [3:0]    red, green, blue;
    logic [11:0]   mem_data;
    logic [11:0]   mem [FBN];
    logic [11:0]   rd_pipe [L];

    vga_fb_scaler #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SCALE(S), .SYNC_POL(SP), .MEM_LAT(L), .ADDR_W(AW)
    ) u_dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce), .pattern_sel(pattern_sel),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .hsync(hsync), .vsync(vsync), .de(de),
      .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    initial begin
      for (int a = 0; a < int'(FBN); a++) mem[a] = 12'($urandom);
      for (int i = 0; i < int'(L); i++) rd_pipe[i] = 12'h000;
    end

    // Synchronous RAM whose read data lags the address by L pixel ticks
    always @(posedge clk) begin
      if (pix_ce) begin
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
      end
    end
    assign mem_data = rd_pipe[L-1];

    // Reference model: outputs derived from the tick index since reset
    int unsigned   t = 0;
    bit            started = 1'b0;
    bit            ticked = 1'b0;
    bit            rst_seen = 1'b0;
    logic [AW-1:0] e_addr;
    logic          e_rd, e_hs, e_vs, e_de, e_fs;
    logic [11:0]   e_rgb;
    logic [1:0]    pat_hist [int];

    always @(posedge clk) begin
      int unsigned h, v, c;
      logic        vis;
      logic [1:0]  p;
      ticked   = 1'b0;
      rst_seen = 1'b0;
      e_fs     = 1'b0;
      if (reset) begin
        started  = 1'b1;
        rst_seen = 1'b1;
        t = 0;
        e_addr = '0; e_rd = 1'b0; e_hs = ~SA; e_vs = ~SA; e_de = 1'b0; e_rgb = 12'h000;
        pat_hist.delete();
      end else if (started && pix_ce) begin
        ticked = 1'b1;
        if (t % FT == 0) pat_hist[int'(t / FT)] = pattern_sel;
        h = t % HT;
        v = (t / HT) % VT;
        vis = (h < HA) && (v < VA);
        e_rd = vis;
        e_addr = vis ? AW'(fb_addr(h, v, S, FBW)) : '0;
        if (t >= L + 1) begin
          c = t - L - 1;
          h = c % HT;
          v = (c / HT) % VT;
          p = pat_hist[int'(c / FT)];
          e_de = (h < HA) && (v < VA);
          e_hs = (h >= HA + HFP && h < HA + HFP + HS) ? SA : ~SA;
          e_vs = (v >= VA + VFP && v < VA + VFP + VS) ? SA : ~SA;
          if (!e_de) e_rgb = 12'h000;
          else if (p == 2'd0) e_rgb = mem[AW'(fb_addr(h, v, S, FBW))];
          else e_rgb = pat_rgb(p, h, v, HA);
          e_fs = (h == 0) && (v == 0);
        end
        t++;
      end
    end

    // Per-clk comparison plus independent sync period/width measurement
    int unsigned per = 0, act = 0, vact = 0;
    bit          prev_hs = 1'b0, prev_vs = 1'b0, have_hs = 1'b0;

    always @(negedge clk) begin
      if (started) begin
        chk(g, "mem_addr", 32'(mem_addr), 32'(e_addr));
        chk(g, "mem_rd", 32'(mem_rd), 32'(e_rd));
        chk(g, "hsync", 32'(hsync), 32'(e_hs));
        chk(g, "vsync", 32'(vsync), 32'(e_vs));
        chk(g, "de", 32'(de), 32'(e_de));
        chk(g, "rgb", 32'({red, green, blue}), 32'(e_rgb));
        chk(g, "frame_start", 32'(frame_start), 32'(e_fs));
        chk(g, "addr_in_range", 32'(32'(mem_addr) <= FBN - 1), 32'd1);
        if (rst_seen) begin
          have_hs = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0; per = 0; act = 0; vact = 0;
        end else if (ticked) begin
          per++;
          if ((hsync == SA) && !prev_hs) begin
            if (have_hs) chk(g, "hsync_period", per, HT);
            have_hs = 1'b1; per = 0; act = 0;
          end
          if (hsync == SA) act++;
          else if (prev_hs) chk(g, "hsync_width", act, HS);
          prev_hs = (hsync == SA);
          if (vsync == SA) begin
            if (!prev_vs) vact = 0;
            vact++;
          end else if (prev_vs) begin
            chk(g, "vsync_width", vact, VS * HT);
          end
          prev_vs = (vsync == SA);
        end
      end
    end
  end

  initial begin
    // Hand-computed pins on the model helpers
    chk(-1, "pin_addr_5_6", fb_addr(5, 6, 4, 8), 9);
    chk(-1, "pin_addr_last_s4", fb_addr(31, 15, 4, 8), 31);
    chk(-1, "pin_addr_last_s2", fb_addr(15, 7, 2, 8), 31);
    chk(-1, "pin_addr_vga_last", fb_addr(639, 479, 4, 160), 19199);
    chk(-1, "pin_bar_x100", 32'(pat_rgb(2'd1, 100, 0, 640)), 32'h00F);
    chk(-1, "pin_bar_x40", 32'(pat_rgb(2'd1, 40, 0, 640)), 32'h000);
    chk(-1, "pin_bar_x13", 32'(pat_rgb(2'd1, 13, 0, 32)), 32'h0FF);
    chk(-1, "pin_grid_on", 32'(pat_rgb(2'd2, 5, 64, 640)), 32'hFFF);
    chk(-1, "pin_grid_off", 32'(pat_rgb(2'd2, 5, 7, 640)), 32'h000);

    reset = 1'b1;
    pix_ce = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Pixel enable every second clk; pattern switched mid-frame
    for (int i = 0; i < 4500; i++) begin
      @(negedge clk);
      pix_ce = ~pix_ce;
      if (i == 1500) pattern_sel = 2'd1;
    end

    // Irregular pixel enable with random pattern requests
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      pix_ce = ($urandom_range(0, 3) != 0);
      if (i % 700 == 350) pattern_sel = 2'($urandom);
    end

    // Reset in the middle of a frame, then continuous pixel enable
    @(negedge clk);
    reset = 1'b1;
    pix_ce = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) pattern_sel = 2'd2;
      if (i == 1000) pattern_sel = 2'd3;
      if (i == 2000) pattern_sel = 2'd0;
    end

    // Reset with the pixel enable low, then random enable again
    reset = 1'b1;
    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pix_ce = ($urandom_range(0, 1) != 0);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
